// File: rtl/paddle_ctrl_gen.sv
// Paddle position controller: synchronised active-low buttons -> saturating y_paddle,
// stepped on a prescaled tick with hold-to-accelerate. Optional auto-tracking via PADDLE_AUTO_EN.
module paddle_ctrl_gen #(
  parameter int POS_W       = 10,
  parameter int POS_MIN     = 0,
  parameter int POS_MAX     = 420,
  parameter int POS_INIT    = 210,
  parameter int WAIT_CYCLES = 2500000,
  parameter int CNT_W       = 22,
  parameter int STEP_SLOW   = 1,
  parameter int STEP_FAST   = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             push1,
  input  logic             push2,
`ifdef PADDLE_AUTO_EN
  input  logic             auto_en,
  input  logic [POS_W-1:0] target_y,
`endif
  output logic [POS_W-1:0] y_paddle,
  output logic             at_min,
  output logic             at_max,
  output logic             fast
);

  typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

  localparam int HW = $clog2(ACCEL_TICKS + 1);
  localparam logic [POS_W:0]   MIN_E  = (POS_W+1)'(POS_MIN);
  localparam logic [POS_W:0]   MAX_E  = (POS_W+1)'(POS_MAX);
  localparam logic [POS_W:0]   S_SLOW = (POS_W+1)'(STEP_SLOW);
  localparam logic [POS_W:0]   S_FAST = (POS_W+1)'(STEP_FAST);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [HW-1:0]    HOLD_TOP = HW'(ACCEL_TICKS);

  logic [1:0]       sync1, sync2;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  state_t           state, state_n;
  logic [HW-1:0]    hold, hold_n, hold_inc;
  logic             dir, dir_n;        // 1 = down (increasing y)
  logic             req_up, req_dn, move, use_fast;
  logic [POS_W:0]   step, y_ext, diff, sum, y_w;

  // Synchronisers idle at 1 so a released button reads as released out of reset
  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {sync1[0], push1};
      sync2 <= {sync2[0], push2};
    end
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= tick ? '0 : cnt + CNT_W'(1);
  end

  assign tick  = (cnt == CNT_TOP);
  assign y_ext = {1'b0, y_paddle};

  always_comb begin
    req_up = !sync1[1] &&  sync2[1];
    req_dn =  sync1[1] && !sync2[1];
`ifdef PADDLE_AUTO_EN
    if (auto_en) begin
      req_up = (target_y < y_paddle);
      req_dn = (target_y > y_paddle);
    end
`endif
  end

  assign hold_inc = (hold == HOLD_TOP) ? hold : hold + HW'(1);

  always_comb begin
    state_n  = state;
    hold_n   = hold;
    dir_n    = dir;
    move     = 1'b0;
    use_fast = 1'b0;
    if (tick && (req_up || req_dn)) begin
      move  = 1'b1;
      dir_n = req_dn;
      case (state)
        IDLE: begin
          state_n = SLOW;
          hold_n  = HW'(1);
        end
        SLOW: begin
          if (req_dn == dir) begin
            hold_n = hold_inc;
            if (hold_inc == HOLD_TOP) state_n = FAST;
          end else begin
            hold_n = HW'(1);
          end
        end
        FAST: begin
          if (req_dn == dir) begin
            use_fast = 1'b1;
            hold_n   = hold_inc;
          end else begin
            state_n = SLOW;
            hold_n  = HW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          hold_n  = '0;
        end
      endcase
    end else if (tick) begin
      state_n = IDLE;
      hold_n  = '0;
    end
  end

  // Clamp in POS_W+1 bits; step > y flags an underflow past zero
  always_comb begin
    step = use_fast ? S_FAST : S_SLOW;
`ifdef PADDLE_AUTO_EN
    if (auto_en) begin
      if ((target_y > y_paddle) && ({1'b0, target_y} - y_ext < step))
        step = {1'b0, target_y} - y_ext;
      else if ((target_y < y_paddle) && (y_ext - {1'b0, target_y} < step))
        step = y_ext - {1'b0, target_y};
    end
`endif
    diff = y_ext - step;
    sum  = y_ext + step;
    y_w  = y_ext;
    if (move) begin
      if (dir_n) y_w = (sum > MAX_E) ? MAX_E : sum;
      else       y_w = ((step > y_ext) || (diff < MIN_E)) ? MIN_E : diff;
    end
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold     <= '0;
      dir      <= 1'b0;
      y_paddle <= POS_W'(POS_INIT);
      at_min   <= (POS_INIT == POS_MIN);
      at_max   <= (POS_INIT == POS_MAX);
      fast     <= 1'b0;
    end else begin
      state    <= state_n;
      hold     <= hold_n;
      dir      <= dir_n;
      y_paddle <= y_w[POS_W-1:0];
      at_min   <= (y_w == MIN_E);
      at_max   <= (y_w == MAX_E);
      fast     <= (state_n == FAST);
    end
  end

endmodule

// File: tb/tb_paddle_ctrl_gen.sv
// Scoreboard bench for paddle_ctrl_gen: stimulus queues expected per-tick results,
// a monitor checks them after each tick and checks the outputs hold in between.
module tb_paddle_ctrl_gen;
  localparam int PW = 4;
  typedef logic [PW+2:0] exp_t;   // {y, at_min, at_max, fast}

  logic in_clk = 1'b0, reset = 1'b0, push1 = 1'b1, push2 = 1'b1;
`ifdef PADDLE_AUTO_EN
  logic auto_en = 1'b0;
  logic [PW-1:0] target_y = '0;
`endif
  logic [PW-1:0] y_paddle;
  logic at_min, at_max, fast;
  exp_t act;

  paddle_ctrl_gen #(
    .POS_W(PW), .POS_MIN(2), .POS_MAX(12), .POS_INIT(7), .WAIT_CYCLES(4),
    .CNT_W(3), .STEP_SLOW(1), .STEP_FAST(3), .ACCEL_TICKS(3)
  ) dut (
    .in_clk(in_clk), .reset(reset), .push1(push1), .push2(push2),
`ifdef PADDLE_AUTO_EN
    .auto_en(auto_en), .target_y(target_y),
`endif
    .y_paddle(y_paddle), .at_min(at_min), .at_max(at_max), .fast(fast)
  );

  always #5 in_clk = ~in_clk;
  assign act = {y_paddle, at_min, at_max, fast};

  exp_t  q[$];
  string qn[$];
  exp_t  held;
  int    n_cmp = 0, n_bad = 0;

  // Independent tick model: upd is high for the cycle after each update edge
  logic [2:0] bcnt;
  logic       upd;
  always @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      bcnt <= 3'd0;
      upd  <= 1'b0;
    end else begin
      bcnt <= (bcnt == 3'd3) ? 3'd0 : bcnt + 3'd1;
      upd  <= (bcnt == 3'd3);
    end
  end

  function automatic exp_t mk(input int y, input bit f);
    logic [PW-1:0] yy;
    yy = PW'(y);
    return {yy, yy == 4'd2, yy == 4'd12, f};
  endfunction

  task automatic chk(input string nm, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s @%0t: got y=%0d min=%b max=%b fast=%b, expected y=%0d min=%b max=%b fast=%b",
               nm, $time, got[6:3], got[2], got[1], got[0], want[6:3], want[2], want[1], want[0]);
    end
  endtask

  initial begin
    exp_t e;
    string nm;
    held = mk(7, 0);
    forever begin
      @(negedge in_clk);
      if (!reset) held = mk(7, 0);
      else if (upd && q.size() > 0) begin
        e  = q.pop_front();
        nm = qn.pop_front();
        chk(nm, act, e);
        held = e;
      end else chk("hold", act, held);
    end
  end

  task automatic wait_upd();
    int k = 0;
    do begin
      @(negedge in_clk);
      k++;
    end while (!upd && k < 20);
    if (!upd) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tick_timeout @%0t: got no update, expected one within 20 clocks", $time);
    end
  endtask

  task automatic tick_exp(input string nm, input int y, input bit f);
    q.push_back(mk(y, f));
    qn.push_back(nm);
    wait_upd();
  endtask

  task automatic do_reset(input logic p1, input logic p2);
    @(negedge in_clk);
    #2 reset = 1'b0;
    #1 chk("reset", act, mk(7, 0));
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover @%0t: got %0d pending, expected 0", $time, q.size());
    end
    q.delete();
    qn.delete();
    push1 = p1;
    push2 = p2;
    @(negedge in_clk);
    reset = 1'b1;
  endtask

  initial begin
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick_exp("idle", 7, 0);

    do_reset(1'b1, 1'b0);
    tick_exp("dn1", 8, 0);
    tick_exp("dn2", 9, 0);
    tick_exp("dn3_fast", 10, 1);
    tick_exp("dn4_clamp", 12, 1);
    tick_exp("dn5_limit", 12, 1);

    do_reset(1'b0, 1'b1);
    tick_exp("up1", 6, 0);
    tick_exp("up2", 5, 0);
    tick_exp("up3_fast", 4, 1);
    tick_exp("up4_clamp", 2, 1);
    tick_exp("up5_limit", 2, 1);

    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick_exp("both", 7, 0);

    do_reset(1'b1, 1'b0);
    tick_exp("rv_dn1", 8, 0);
    tick_exp("rv_dn2", 9, 0);
    tick_exp("rv_fast", 10, 1);
    push1 = 1'b0; push2 = 1'b1;
    tick_exp("rv_opp", 9, 0);
    push1 = 1'b1;
    tick_exp("rv_idle", 9, 0);
    push2 = 1'b0;
    tick_exp("rv_restart1", 10, 0);
    tick_exp("rv_restart2", 11, 0);

    do_reset(1'b0, 1'b1);
    tick_exp("mr_up1", 6, 0);
    tick_exp("mr_up2", 5, 0);
    push1 = 1'b1; push2 = 1'b0;
    tick_exp("mr_dn1", 6, 0);
    tick_exp("mr_dn2", 7, 0);
    tick_exp("mr_fast", 8, 1);
    tick_exp("mr_fast11", 11, 1);
    do_reset(1'b1, 1'b0);
    tick_exp("mr_first", 8, 0);

`ifdef PADDLE_AUTO_EN
    do_reset(1'b1, 1'b1);
    auto_en  = 1'b1;
    target_y = 4'd9;
    tick_exp("auto1", 8, 0);
    tick_exp("auto2", 9, 0);
    tick_exp("auto_hold", 9, 0);
`endif

    @(negedge in_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
